// File: rtl/adc_multi_ch_capture.sv
// rtl/adc_multi_ch_capture.sv - multi-channel ADC pre/post trigger capture buffer (option macro ADC_CAPTURE_TEST_PATTERN_EN)
module adc_multi_ch_capture #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 12,
   parameter int DEPTH      = 1024,
   localparam int AW        = $clog2(DEPTH)
)(
   input  logic                         clk,
   input  logic                         rstn,
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
   input  logic                         test_mode,
`endif
   input  logic                         sample_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] sample_data,
   input  logic                         arm,
   input  logic                         abort,
   input  logic                         trig_in,
   input  logic [AW-1:0]                pre_samples,
   input  logic [AW:0]                  post_samples,
   input  logic                         rd_en,
   output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
   output logic                         rd_valid,
   output logic                         busy,
   output logic                         done,
   output logic [AW:0]                  frames_left
);

   localparam int          FW      = NUM_CH * DATA_WIDTH;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_W   = (AW+1)'(1);

   typedef enum logic [2:0] {IDLE, PRE_FILL, WAIT_TRIG, POST, DONE} state_t;

   state_t        state, state_nxt;
   logic [FW-1:0] mem [DEPTH];
   logic [FW-1:0] wr_frame;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt, pre_len, post_len, left, total;
   logic [AW:0]   pre_clamp, post_clamp;
   logic          trig_prev, arm_ok;
   logic          trig_hit, pop, wr_en;

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
   logic [DATA_WIDTH-1:0] ramp;

   // Ramp source advances on every presented frame regardless of state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)             ramp <= '0;
      else if (sample_valid) ramp <= ramp + DATA_WIDTH'(1);
   end

   // Substitute ramp+k per channel when the test pattern is selected.
   always_comb begin
      wr_frame = sample_data;
      if (test_mode) begin
         for (int k = 0; k < NUM_CH; k++)
            wr_frame[k*DATA_WIDTH +: DATA_WIDTH] = ramp + DATA_WIDTH'(k);
      end
   end
`else
   assign wr_frame = sample_data;
`endif

   // Arm-time clamping; an AW-bit pre_samples can never exceed DEPTH-1.
   always_comb begin
      pre_clamp  = {1'b0, pre_samples};
      post_clamp = (post_samples > (DEPTH_W - pre_clamp)) ? (DEPTH_W - pre_clamp) : post_samples;
      total      = pre_len + post_len;
      trig_hit   = (state == WAIT_TRIG) && sample_valid && trig_in && !trig_prev;
      pop        = (state == DONE) && rd_en && (left != '0);
      // A post=0 trigger frame is deliberately not stored.
      wr_en      = sample_valid &&
                   ((state == PRE_FILL) || (state == POST) ||
                    ((state == WAIT_TRIG) && !(trig_hit && (post_len == '0))));
   end

   // Next-state logic; abort overrides every transition.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (arm && arm_ok) state_nxt = (pre_clamp == '0) ? WAIT_TRIG : PRE_FILL;
         PRE_FILL:  if (sample_valid && (cnt + ONE_W == pre_len)) state_nxt = WAIT_TRIG;
         WAIT_TRIG: if (trig_hit) state_nxt = (post_len <= ONE_W) ? DONE : POST;
         POST:      if (sample_valid && (cnt + ONE_W == post_len)) state_nxt = DONE;
         DONE:      if ((left == '0) || (pop && (left == ONE_W))) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   // Capture buffer storage, no reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_frame;
   end

   // State, pointers, counters and readout registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         pre_len   <= '0;
         post_len  <= '0;
         left      <= '0;
         trig_prev <= 1'b0;
         arm_ok    <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
      end else begin
         state     <= state_nxt;
         trig_prev <= trig_in;
         arm_ok    <= 1'b1;
         rd_valid  <= pop && !abort;
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + AW'(1);
            left    <= left - ONE_W;
         end
         // The trigger frame already counts as post frame 1.
         if ((state == WAIT_TRIG) && (state_nxt == POST))
            cnt <= ONE_W;
         else if (state != state_nxt)
            cnt <= '0;
         else if (sample_valid && ((state == PRE_FILL) || (state == POST)))
            cnt <= cnt + ONE_W;
         if ((state == IDLE) && (state_nxt != IDLE)) begin
            pre_len  <= pre_clamp;
            post_len <= post_clamp;
         end
         // Oldest retained frame sits total frames behind the next write slot.
         if ((state_nxt == DONE) && (state != DONE)) begin
            left   <= total;
            rd_ptr <= wr_ptr + AW'(wr_en) - total[AW-1:0];
         end
         if (abort) left <= '0;
      end
   end

   assign busy        = (state == PRE_FILL) || (state == WAIT_TRIG) || (state == POST);
   assign done        = (state == DONE);
   assign frames_left = (state == DONE) ? left : '0;

endmodule

// File: tb/tb_adc_multi_ch_capture.sv
// tb/tb_adc_multi_ch_capture.sv - scoreboard bench for adc_multi_ch_capture (option macro ADC_CAPTURE_TEST_PATTERN_EN)
module tb_adc_multi_ch_capture;

   localparam int NUM_CH     = 4;
   localparam int DATA_WIDTH = 12;
   localparam int DEPTH      = 16;
   localparam int AW         = 4;
   localparam int FW         = NUM_CH * DATA_WIDTH;

   logic          clk = 1'b0;
   logic          rstn;
   logic          sample_valid;
   logic [FW-1:0] sample_data;
   logic          arm, abort, trig_in, rd_en;
   logic [AW-1:0] pre_samples;
   logic [AW:0]   post_samples;
   logic [FW-1:0] rd_data;
   logic          rd_valid, busy, done;
   logic [AW:0]   frames_left;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
   logic          test_mode;
`endif

   int            checks = 0;
   int            errors = 0;
   logic [FW-1:0] exp_q[$];

   adc_multi_ch_capture #(.NUM_CH(NUM_CH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rstn         (rstn),
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
      .test_mode    (test_mode),
`endif
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .arm          (arm),
      .abort        (abort),
      .trig_in      (trig_in),
      .pre_samples  (pre_samples),
      .post_samples (post_samples),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .busy         (busy),
      .done         (done),
      .frames_left  (frames_left)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Frame n carries n + 256*k on channel k.
   function automatic logic [FW-1:0] frame(input int n);
      logic [FW-1:0] f;
      for (int k = 0; k < NUM_CH; k++) f[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(n + 256*k);
      return f;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic send(input int n, input logic trig);
      sample_valid = 1'b1;
      sample_data  = frame(n);
      trig_in      = trig;
      cyc();
      sample_valid = 1'b0;
   endtask

   task automatic send_range(input int first, input int last);
      for (int n = first; n <= last; n++) send(n, 1'b0);
   endtask

   task automatic do_arm(input int pre, input int post);
      pre_samples  = AW'(pre);
      post_samples = (AW+1)'(post);
      arm = 1'b1;
      cyc();
      arm = 1'b0;
   endtask

   task automatic push_range(input int first, input int last);
      for (int n = first; n <= last; n++) exp_q.push_back(frame(n));
   endtask

   task automatic read_n(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         rd_en = 1'b1;
         cyc();
         check("rd_valid_latency", int'(rd_valid), 1);
      end
      rd_en = 1'b0;
      check("done_after_last_pop", int'(done), 0);
      cyc();
      check("no_extra_rd_valid", int'(rd_valid), 0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a frame.
   always @(negedge clk) begin
      logic [FW-1:0] e;
      if (rstn && rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected actual=%h required=none", rd_data);
         end else begin
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               errors++;
               $display("FAIL rd_data actual=%h required=%h", rd_data, e);
            end
         end
      end
   end

   // Watchdog bound on the whole run.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0; sample_valid = 1'b0; sample_data = '0; arm = 1'b0; abort = 1'b0;
      trig_in = 1'b0; rd_en = 1'b0; pre_samples = '0; post_samples = '0;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
      test_mode = 1'b0;
`endif
      cyc(); cyc();
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_frames_left", int'(frames_left), 0);
      check("reset_rd_valid", int'(rd_valid), 0);
      check("reset_rd_data_zero", int'(rd_data == '0), 1);
      rstn = 1'b1;
      cyc(); cyc();

      // rd_en in IDLE is ignored.
      rd_en = 1'b1; cyc(); rd_en = 1'b0;
      check("idle_rd_ignored", int'(rd_valid), 0);

      // Basic capture: pre=4 post=4, trigger on frame 10.
      do_arm(4, 4);
      check("t1_busy_after_arm", int'(busy), 1);
      send_range(0, 9);
      send(10, 1'b1);
      send(11, 1'b0); send(12, 1'b0);
      check("t1_not_done_early", int'(done), 0);
      send(13, 1'b0);
      check("t1_done", int'(done), 1);
      check("t1_busy_clear", int'(busy), 0);
      check("t1_frames_left", int'(frames_left), 8);
      push_range(6, 13);
      read_n(8);

      // Clamping: pre=15 (max), post=10 clamped to 1, wraps the buffer.
      do_arm(15, 10);
      send_range(100, 119);
      send(120, 1'b1);
      check("t2_done", int'(done), 1);
      check("t2_frames_left", int'(frames_left), 16);
      push_range(105, 120);
      read_n(16);

      // trig held high through arm, edge in PRE_FILL ignored.
      trig_in = 1'b1;
      do_arm(3, 2);
      send(200, 1'b1); send(201, 1'b0); send(202, 1'b1);
      send(203, 1'b1); send(204, 1'b1);
      check("t3_no_trig_while_high", int'(busy), 1);
      send(205, 1'b0);
      send(206, 1'b1);
      send(207, 1'b0);
      check("t3_done", int'(done), 1);
      check("t3_frames_left", int'(frames_left), 5);
      push_range(203, 207);
      read_n(5);

      // abort in POST, abort beats arm, then clean re-arm.
      do_arm(2, 4);
      send(300, 1'b0); send(301, 1'b0); send(302, 1'b0); send(303, 1'b1); send(304, 1'b0);
      abort = 1'b1; cyc(); abort = 1'b0;
      check("t4_abort_busy", int'(busy), 0);
      check("t4_abort_frames_left", int'(frames_left), 0);
      trig_in = 1'b0;
      abort = 1'b1; arm = 1'b1; cyc(); abort = 1'b0; arm = 1'b0;
      check("t4_abort_wins", int'(busy), 0);
      do_arm(2, 2);
      send(310, 1'b0); send(311, 1'b0); send(312, 1'b0); send(313, 1'b1); send(314, 1'b0);
      check("t4_rearm_frames_left", int'(frames_left), 4);
      push_range(311, 312);
      rd_en = 1'b1;
      cyc(); cyc(); cyc();
      rd_en = 1'b0;
      rstn = 1'b0;
      #1;
      check("t4_rst_rd_valid", int'(rd_valid), 0);
      check("t4_rst_done", int'(done), 0);
      check("t4_rst_frames_left", int'(frames_left), 0);
      cyc();
      rstn = 1'b1;
      pre_samples = AW'(1); post_samples = (AW+1)'(1);
      arm = 1'b1; cyc(); arm = 1'b0;
      check("t4_arm_too_early", int'(busy), 0);
      cyc();

      // post=0: trigger frame not stored.
      do_arm(3, 0);
      send_range(400, 404);
      send(405, 1'b1);
      check("t5_done", int'(done), 1);
      check("t5_frames_left", int'(frames_left), 3);
      push_range(402, 404);
      read_n(3);

      // arm+trig+valid together in IDLE with pre=0 is not a trigger.
      pre_samples = '0; post_samples = (AW+1)'(2);
      arm = 1'b1; send(500, 1'b1); arm = 1'b0;
      send(501, 1'b1);
      check("t6_no_false_trig", int'(done), 0);
      check("t6_waiting", int'(busy), 1);
      send(502, 1'b0); send(503, 1'b1); send(504, 1'b0);
      check("t6_frames_left", int'(frames_left), 2);
      push_range(503, 504);
      read_n(2);

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
      // Test pattern from a fresh reset: ramp starts at 0.
      rstn = 1'b0; cyc(); rstn = 1'b1; cyc(); cyc();
      test_mode = 1'b1;
      do_arm(1, 1);
      send(0, 1'b0);
      send(0, 1'b1);
      check("tp_frames_left", int'(frames_left), 2);
      exp_q.push_back({12'd3, 12'd2, 12'd1, 12'd0});
      exp_q.push_back({12'd4, 12'd3, 12'd2, 12'd1});
      read_n(2);
      test_mode = 1'b0;
`endif

      cyc();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
